// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall-side companion of the EX forwarding unit.
// Tracks destination-register info for instructions in EX, MEM and WB,
// detects load-use hazards, and drives PC / IF/ID enables and ID/EX bubble.
module hazard_scoreboard #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_RegWrite,
    input  logic             id_MemRead,
    input  logic             flush,
    input  logic             mem_busy,
    output logic             stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic [31:0]      busy_vec,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } entry_t;

    localparam entry_t ENTRY_NONE = '{valid: 1'b0, rd: 5'd0, reg_write: 1'b0, mem_read: 1'b0};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    entry_t           ex_q, ex_d;
    entry_t           mem_q, mem_d;
    entry_t           wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu_s;
    logic             stall_s;
    logic [31:0]      busy_s;

    // True when entry e is an in-flight write to architectural register r (x0 never counts).
    function automatic logic writes_reg(input entry_t e, input logic [4:0] r);
        return e.valid & e.reg_write & (e.rd == r) & (r != 5'd0);
    endfunction

    // Load-use detection: only a load sitting in EX can't be forwarded in time.
    always_comb begin
        lu_s = 1'b0;
        if (id_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.rd != 5'd0)) begin
            lu_s = (ex_q.rd == id_rs1) | (id_use_rs2 & (ex_q.rd == id_rs2));
        end else begin
            lu_s = 1'b0;
        end
    end

    // Pipeline control: flush beats a stall, and a memory freeze suppresses both.
    always_comb begin
        stall_s     = lu_s & ~flush & ~mem_busy;
        stall       = stall_s;
        pc_write    = ~(stall_s | mem_busy);
        ifid_write  = ~(stall_s | mem_busy);
        idex_bubble = (stall_s | flush) & ~mem_busy;
    end

    // Busy vector: any shadow entry that will write xr marks bit r.
    always_comb begin
        busy_s = 32'd0;
        for (int r = 1; r < 32; r++) begin
            busy_s[r] = writes_reg(ex_q, 5'(r)) | writes_reg(mem_q, 5'(r)) | writes_reg(wb_q, 5'(r));
        end
        busy_vec = busy_s;
    end

    // Next state: shadow pipeline advances unless memory is busy; counter saturates.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        cnt_d = cnt_q;
        if (!mem_busy) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (stall_s || flush || !id_valid) begin
                ex_d = ENTRY_NONE;
            end else begin
                ex_d = '{valid: 1'b1, rd: id_rd, reg_write: id_RegWrite, mem_read: id_MemRead};
            end
            if (stall_s && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            ex_d  = ex_q;
            mem_d = mem_q;
            wb_d  = wb_q;
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset that overrides freeze and flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= ENTRY_NONE;
            mem_q <= ENTRY_NONE;
            wb_q  <= ENTRY_NONE;
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: one cycle per table row, expected
// outputs queued at drive time and compared mid-cycle. A second instance with a
// 2-bit counter sees the same stimulus to check saturation.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs2, id_RegWrite, id_MemRead, flush, mem_busy;

    logic        stall, pc_write, ifid_write, idex_bubble;
    logic [31:0] busy_vec;
    logic [15:0] stall_cnt;

    logic        s_stall, s_pc_write, s_ifid_write, s_idex_bubble;
    logic [31:0] s_busy_vec;
    logic [1:0]  s_stall_cnt;

    int checks   = 0;
    int failures = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    hazard_scoreboard #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_RegWrite(id_RegWrite),
        .id_MemRead(id_MemRead), .flush(flush), .mem_busy(mem_busy),
        .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_bubble(idex_bubble), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_RegWrite(id_RegWrite),
        .id_MemRead(id_MemRead), .flush(flush), .mem_busy(mem_busy),
        .stall(s_stall), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .idex_bubble(s_idex_bubble), .busy_vec(s_busy_vec), .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        logic        rst, v;
        logic [4:0]  rs1, rs2;
        logic        use2;
        logic [4:0]  rd;
        logic        rw, mr, fl, mb;
        logic        chk;
        logic        e_stall, e_pcw, e_bub;
        logic [31:0] e_busy;
        logic [15:0] e_cnt;
        logic        chk_sat;
        logic [1:0]  e_sat;
    } vec_t;

    vec_t tbl[$];
    vec_t expq[$];

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic use2, input logic [4:0] rd, input logic rw,
                                input logic mr, input logic fl, input logic mb,
                                input logic es, input logic epw, input logic eb,
                                input logic [31:0] ebusy, input logic [15:0] ecnt);
        vec_t t;
        t.rst = 1'b0; t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.use2 = use2; t.rd = rd;
        t.rw = rw; t.mr = mr; t.fl = fl; t.mb = mb; t.chk = 1'b1;
        t.e_stall = es; t.e_pcw = epw; t.e_bub = eb; t.e_busy = ebusy; t.e_cnt = ecnt;
        t.chk_sat = 1'b0; t.e_sat = 2'd0;
        return t;
    endfunction

    function automatic vec_t idle(input logic [31:0] ebusy, input logic [15:0] ecnt);
        return mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b1, 1'b0, ebusy, ecnt);
    endfunction

    function automatic vec_t lw(input logic [4:0] rd, input logic [31:0] ebusy, input logic [15:0] ecnt);
        return mk(1'b1, 5'd0, 5'd0, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0,
                  1'b0, 1'b1, 1'b0, ebusy, ecnt);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h expected=%h", name, idx, got, exp);
        end
    endtask

    // Drive one row just after the rising edge, compare on the falling edge.
    task automatic step(input vec_t t, input int idx);
        vec_t e;
        @(posedge clk);
        #1;
        rst = t.rst; id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2; id_use_rs2 = t.use2;
        id_rd = t.rd; id_RegWrite = t.rw; id_MemRead = t.mr; flush = t.fl; mem_busy = t.mb;
        expq.push_back(t);
        @(negedge clk);
        e = expq.pop_front();
        if (e.chk) begin
            check("stall",       idx, {31'd0, stall},       {31'd0, e.e_stall});
            check("pc_write",    idx, {31'd0, pc_write},    {31'd0, e.e_pcw});
            check("ifid_write",  idx, {31'd0, ifid_write},  {31'd0, e.e_pcw});
            check("idex_bubble", idx, {31'd0, idex_bubble}, {31'd0, e.e_bub});
            check("busy_vec",    idx, busy_vec,             e.e_busy);
            check("stall_cnt",   idx, {16'd0, stall_cnt},   {16'd0, e.e_cnt});
        end
        if (e.chk_sat) begin
            check("sat_cnt", idx, {30'd0, s_stall_cnt}, {30'd0, e.e_sat});
        end
    endtask

    initial begin
        vec_t t;
        int   row = 0;
        rst = 1'b1; id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b0;
        id_rd = 5'd0; id_RegWrite = 1'b0; id_MemRead = 1'b0; flush = 1'b0; mem_busy = 1'b0;

        // Reset for two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            t = mk(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'b0, 1'b1, 1'b0, 32'd0, 16'd0);
            t.rst = 1'b1; t.chk = 1'b0;
            step(t, row++);
        end

        // Table: post-reset state, load-use, no-stall, flush, freeze, rs2, dup rd.
        tbl.push_back(idle(32'h0, 16'd0));
        tbl.push_back(lw(5'd5, 32'h0, 16'd0));
        tbl.push_back(mk(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 16'd0));
        tbl.push_back(mk(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 16'd1));
        tbl.push_back(idle(32'h60, 16'd1));
        tbl.push_back(idle(32'h40, 16'd1));
        tbl.push_back(idle(32'h40, 16'd1));
        tbl.push_back(lw(5'd5, 32'h0, 16'd1));
        tbl.push_back(mk(1'b1, 5'd0, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 16'd1));
        tbl.push_back(lw(5'd0, 32'h60, 16'd1));
        tbl.push_back(mk(1'b1, 5'd0, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h60, 16'd1));
        tbl.push_back(idle(32'h42, 16'd1));
        tbl.push_back(idle(32'h02, 16'd1));
        tbl.push_back(idle(32'h02, 16'd1));
        tbl.push_back(lw(5'd5, 32'h0, 16'd1));
        tbl.push_back(mk(1'b1, 5'd5, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 16'd1));
        tbl.push_back(idle(32'h20, 16'd1));
        tbl.push_back(idle(32'h20, 16'd1));
        tbl.push_back(lw(5'd5, 32'h0, 16'd1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 16'd1));
        tbl.push_back(mk(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 16'd1));
        tbl.push_back(mk(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 16'd2));
        tbl.push_back(idle(32'h60, 16'd2));
        tbl.push_back(idle(32'h40, 16'd2));
        tbl.push_back(idle(32'h40, 16'd2));
        tbl.push_back(idle(32'h0, 16'd2));
        tbl.push_back(lw(5'd9, 32'h0, 16'd2));
        tbl.push_back(mk(1'b1, 5'd1, 5'd9, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 16'd2));
        tbl.push_back(mk(1'b1, 5'd1, 5'd9, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 16'd3));
        tbl.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h208, 16'd3));
        tbl.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h208, 16'd3));
        tbl.push_back(idle(32'h08, 16'd3));
        tbl.push_back(idle(32'h08, 16'd3));
        tbl.push_back(idle(32'h0, 16'd3));
        tbl.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 16'd3));
        tbl.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 16'd3));
        tbl.push_back(idle(32'h20, 16'd3));
        tbl.push_back(idle(32'h20, 16'd3));
        tbl.push_back(idle(32'h20, 16'd3));
        tbl.push_back(idle(32'h0, 16'd3));
        tbl.push_back(lw(5'd5, 32'h0, 16'd3));
        tbl.push_back(mk(1'b0, 5'd5, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 16'd3));
        tbl.push_back(idle(32'h20, 16'd3));
        tbl.push_back(idle(32'h20, 16'd3));
        tbl.push_back(idle(32'h0, 16'd3));
        foreach (tbl[i]) step(tbl[i], row++);

        // Reset mid-stall: the stall edge must not count.
        step(lw(5'd5, 32'h0, 16'd3), row++);
        t = mk(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 16'd3);
        t.rst = 1'b1; t.chk = 1'b0;
        step(t, row++);
        t = idle(32'h0, 16'd0); t.chk_sat = 1'b1; t.e_sat = 2'd0;
        step(t, row++);

        // Reset mid-freeze with flush pending.
        step(lw(5'd5, 32'h0, 16'd0), row++);
        step(mk(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 16'd0), row++);
        t = mk(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 16'd0);
        t.rst = 1'b1; t.chk = 1'b0;
        step(t, row++);
        t = idle(32'h0, 16'd0); t.chk_sat = 1'b1; t.e_sat = 2'd0;
        step(t, row++);

        // Five back-to-back load-use stalls: 2-bit counter goes 1,2,3,3,3.
        for (int k = 1; k <= 5; k++) begin
            t = lw(5'd5, (k == 1) ? 32'h0 : 32'h20, 16'(k - 1));
            t.chk_sat = 1'b1; t.e_sat = (k - 1 > 3) ? 2'd3 : 2'(k - 1);
            step(t, row++);
            step(mk(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 16'(k - 1)), row++);
        end
        t = idle(32'h20, 16'd5); t.chk_sat = 1'b1; t.e_sat = 2'd3;
        step(t, row++);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
